// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues IMEM reads, buffers the 1-cycle-latency
// responses in a 2-entry FIFO and hands {instr, pc} to decode over valid/ready.
module instr_fetch #(
  parameter int unsigned ADDR_DEPTH = 14,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic                  o_imem_rden,
  output logic [ADDR_DEPTH-1:0] o_imem_addr,
  input  logic [31:0]           i_imem_data,
  input  logic                  i_redirect,
  input  logic [31:0]           i_redirect_pc,
  output logic                  o_instr_valid,
  input  logic                  i_instr_ready,
  output logic [31:0]           o_instr,
  output logic [31:0]           o_instr_pc
);

  logic [31:0] r_pc;
  logic        r_inflight;
  logic [31:0] r_req_pc;
  logic [31:0] r_fifo_pc    [2];
  logic [31:0] r_fifo_instr [2];
  logic        r_head;
  logic [1:0]  r_occ;

  logic        w_valid;
  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic        w_tail;
  logic [2:0]  w_level;
  logic [31:0] w_req_pc;

  // Level counts buffered entries plus the response still in flight, net of this cycle's pop.
  always_comb begin
    w_valid  = (r_occ != 2'd0);
    w_pop    = w_valid & i_instr_ready;
    w_level  = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_issue  = i_rst_n & (i_redirect | (w_level < 3'd2));
    w_req_pc = i_redirect ? (i_redirect_pc & 32'hFFFF_FFFC) : r_pc;
    w_push   = r_inflight & ~i_redirect;
    w_tail   = r_head ^ r_occ[0];
  end

  always_comb begin
    o_imem_rden   = w_issue;
    o_imem_addr   = w_req_pc[ADDR_DEPTH+1:2];
    o_instr_valid = w_valid;
    o_instr       = w_valid ? r_fifo_instr[r_head] : 32'h0;
    o_instr_pc    = w_valid ? r_fifo_pc[r_head]    : 32'h0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_req_pc   <= 32'h0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_req_pc <= w_req_pc;
        r_pc     <= w_req_pc + 32'd4;
      end
    end
  end

  // A redirect drops both the buffered entries and the response arriving this cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_occ  <= 2'd0;
      r_head <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_pc[i]    <= 32'h0;
        r_fifo_instr[i] <= 32'h0;
      end
    end else if (i_redirect) begin
      r_occ  <= 2'd0;
      r_head <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo_pc[w_tail]    <= r_req_pc;
        r_fifo_instr[w_tail] <= i_imem_data;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                  !(w_push && (r_occ == 2'd2)));

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised scoreboard bench for instr_fetch: the expected stream is PC, PC+4, ...
// from the last reset/redirect target, with IMEM word = 0xA000_0000 + word index.
module tb_instr_fetch;
  localparam int unsigned AD     = 14;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rden;
  logic [AD-1:0] addr;
  logic [31:0]   imem_data = 32'h0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic          valid;
  logic          ready = 1'b0;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;

  always #5 clk = ~clk;

  instr_fetch #(
    .ADDR_DEPTH (AD),
    .RESET_PC   (RST_PC)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_imem_rden   (rden),
    .o_imem_addr   (addr),
    .i_imem_data   (imem_data),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_instr_valid (valid),
    .i_instr_ready (ready),
    .o_instr       (instr),
    .o_instr_pc    (instr_pc)
  );

  // Synchronous ROM: drives the addressed word the cycle after a read, zero otherwise.
  always @(posedge clk) begin
    imem_data <= rden ? (32'hA000_0000 + {{(32 - AD){1'b0}}, addr}) : 32'h0;
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] next_pc;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_hs = 0;
  int          hs0;

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return 32'hA000_0000 + ((pc >> 2) % (32'd1 << AD));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic topup();
    exp_t e;
    while (exp_q.size() < 8) begin
      e.pc    = next_pc;
      e.instr = exp_instr(next_pc);
      exp_q.push_back(e);
      next_pc = next_pc + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] p);
    exp_q.delete();
    next_pc = p & 32'hFFFF_FFFC;
    topup();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    topup();
  endtask

  // Handshakes in a redirect cycle belong to the discarded stream.
  always @(negedge clk) begin
    if (rst_n && valid && ready && !redirect) begin
      n_hs++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty: got pc %h expected no delivery", instr_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("instr_pc", instr_pc, mon_e.pc);
        check("instr", instr, mon_e.instr);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    next_pc = RST_PC;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rden", {31'b0, rden}, 32'd0);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready = 1'b1;
    restart(RST_PC);
    @(negedge clk);
    check("first_rden", {31'b0, rden}, 32'd1);
    check("first_addr", {{(32 - AD){1'b0}}, addr}, (RST_PC >> 2) % (32'd1 << AD));
    check("first_valid", {31'b0, valid}, 32'd0);
    cyc();
    @(negedge clk);
    check("lat_valid_c1", {31'b0, valid}, 32'd0);
    cyc();
    @(negedge clk);
    check("lat_valid_c2", {31'b0, valid}, 32'd1);
    check("lat_pc_c2", instr_pc, RST_PC);
    for (int i = 0; i < 8; i++) begin
      cyc();
      @(negedge clk);
      check("stream_valid", {31'b0, valid}, 32'd1);
      check("stream_rden", {31'b0, rden}, 32'd1);
    end

    // Backpressure: issue must stop once buffer plus in-flight hold two.
    cyc();
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc();
      @(negedge clk);
      if (i >= 2) check("bp_rden", {31'b0, rden}, 32'd0);
      check("bp_valid", {31'b0, valid}, 32'd1);
    end
    cyc();
    ready = 1'b1;
    @(negedge clk);
    check("bp_resume_rden", {31'b0, rden}, 32'd1);
    repeat (4) cyc();

    cyc();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    restart(redirect_pc);
    @(negedge clk);
    check("redir_rden", {31'b0, rden}, 32'd1);
    check("redir_addr", {{(32 - AD){1'b0}}, addr}, 32'h40);
    cyc();
    redirect = 1'b0;
    @(negedge clk);
    check("redir_valid_r1", {31'b0, valid}, 32'd0);
    cyc();
    @(negedge clk);
    check("redir_valid_r2", {31'b0, valid}, 32'd1);
    check("redir_pc_r2", instr_pc, 32'h100);
    repeat (4) cyc();

    // Redirect while the buffer is occupied and decode is stalled.
    for (int v = 0; v < 2; v++) begin
      cyc();
      ready = 1'b0;
      repeat (v * 2) cyc();
      redirect = 1'b1;
      redirect_pc = 32'h2000 + 32'(v * 64);
      restart(redirect_pc);
      cyc();
      redirect = 1'b0;
      ready = 1'b1;
      @(negedge clk);
      check("flush_valid_r1", {31'b0, valid}, 32'd0);
      cyc();
      @(negedge clk);
      check("flush_valid_r2", {31'b0, valid}, 32'd1);
      check("flush_pc_r2", instr_pc, 32'h2000 + 32'(v * 64));
      repeat (3) cyc();
    end

    cyc();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    restart(redirect_pc);
    @(negedge clk);
    check("wrap_addr_r0", {{(32 - AD){1'b0}}, addr}, 32'h3FFF);
    cyc();
    redirect = 1'b0;
    @(negedge clk);
    check("wrap_rden_r1", {31'b0, rden}, 32'd1);
    check("wrap_addr_r1", {{(32 - AD){1'b0}}, addr}, 32'h0);
    cyc();
    @(negedge clk);
    check("wrap_pc_r2", instr_pc, 32'hFFFF_FFFC);
    cyc();
    @(negedge clk);
    check("wrap_pc_r3", instr_pc, 32'h0);
    repeat (3) cyc();

    // Reset pulse while a response is in flight and an entry is buffered.
    cyc();
    ready = 1'b0;
    rst_n = 1'b0;
    restart(RST_PC);
    @(negedge clk);
    check("mid_rst_rden", {31'b0, rden}, 32'd0);
    check("mid_rst_valid", {31'b0, valid}, 32'd0);
    check("mid_rst_instr", instr, 32'd0);
    check("mid_rst_pc", instr_pc, 32'd0);
    cyc();
    rst_n = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    check("mid_rel_rden", {31'b0, rden}, 32'd1);
    check("mid_rel_addr", {{(32 - AD){1'b0}}, addr}, (RST_PC >> 2) % (32'd1 << AD));
    check("mid_rel_valid", {31'b0, valid}, 32'd0);
    cyc();
    @(negedge clk);
    check("mid_rel_valid_c1", {31'b0, valid}, 32'd0);
    cyc();
    @(negedge clk);
    check("mid_rel_valid_c2", {31'b0, valid}, 32'd1);
    check("mid_rel_pc_c2", instr_pc, RST_PC);

    for (int i = 0; i < 1500; i++) begin
      cyc();
      ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 15) == 0);
      if (redirect) begin
        redirect_pc = $urandom;
        restart(redirect_pc);
      end
    end

    cyc();
    redirect = 1'b0;
    ready = 1'b1;
    hs0 = n_hs;
    repeat (20) cyc();
    n_checks++;
    if (n_hs - hs0 < 15) begin
      n_fail++;
      $display("FAIL drain_progress: got %0d handshakes expected at least 15", n_hs - hs0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
